// File: rtl/clock_set_pkg.sv
// Shared types and constants for the HH:MM:SS time-setting controller.
// Holds the FSM state enum, field indices, BCD limits and display mask layout.
package clock_set_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_HOUR,
    ST_SET_MIN,
    ST_SET_SEC,
    ST_COMMIT
  } state_t;

  localparam logic [1:0] FLD_SEC  = 2'd0;
  localparam logic [1:0] FLD_MIN  = 2'd1;
  localparam logic [1:0] FLD_HOUR = 2'd2;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  localparam logic [7:0] LE_SEC_BITS  = 8'h03;
  localparam logic [7:0] LE_MIN_BITS  = 8'h0C;
  localparam logic [7:0] LE_HOUR_BITS = 8'h30;
  localparam logic [7:0] LE_IDLE      = 8'hC0;

  // A captured field the counters could never legally hold is replaced by 00.
  function automatic logic [7:0] bcd_sanitize(input logic [7:0] f, input logic is_hour);
    if (f[7:4] > 4'd9 || f[3:0] > 4'd9 || (is_hour && f[7:4] > 4'd2))
      return 8'h00;
    return f;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button, counter-chain and display-driver signals of the time-setting controller.
// Optional btn_dec exists only when CLKSET_DEC_EN is defined.
interface clock_set_ctrl_if;
  logic        btn_mode;
  logic        btn_inc;
`ifdef CLKSET_DEC_EN
  logic        btn_dec;
`endif
  logic        tick_1s;
  logic [23:0] cur_time;
  logic        run_en;
  logic        ld_n;
  logic [23:0] set_time;
  logic [7:0]  le_mask;
  logic        editing;

`ifdef CLKSET_DEC_EN
  modport master (output btn_mode, btn_inc, btn_dec, tick_1s, cur_time,
                  input  run_en, ld_n, set_time, le_mask, editing);
  modport slave  (input  btn_mode, btn_inc, btn_dec, tick_1s, cur_time,
                  output run_en, ld_n, set_time, le_mask, editing);
`else
  modport master (output btn_mode, btn_inc, tick_1s, cur_time,
                  input  run_en, ld_n, set_time, le_mask, editing);
  modport slave  (input  btn_mode, btn_inc, tick_1s, cur_time,
                  output run_en, ld_n, set_time, le_mask, editing);
`endif
endinterface

// File: rtl/bcd_field_step.sv
// Combinational +1/-1 on a two-digit BCD field, wrapping between 00 and max_i.
// Zero latency, no flow control.
module bcd_field_step (
  input  logic [7:0] val_i,
  input  logic [7:0] max_i,
  input  logic       up_i,
  output logic [7:0] res_o
);

  always_comb begin
    res_o = val_i;
    if (up_i) begin
      // >= also pulls an out-of-range hour like 0x29 back to 00.
      if (val_i >= max_i)
        res_o = 8'h00;
      else if (val_i[3:0] >= 4'd9)
        res_o = {val_i[7:4] + 4'd1, 4'd0};
      else
        res_o = val_i + 8'd1;
    end else begin
      if (val_i == 8'h00)
        res_o = max_i;
      else if (val_i[3:0] == 4'd0)
        res_o = {val_i[7:4] - 4'd1, 4'd9};
      else
        res_o = val_i - 8'd1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Freezes the BCD counter chain, edits HH:MM:SS with blinking field, loads on next 1 s edge.
// Presses act 3 clk after the button edge; CLKSET_DEC_EN adds a decrement button.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000,
  parameter int TIMEOUT_S = 30
) (
  input logic             clk,
  input logic             rst_n,
  clock_set_ctrl_if.slave bus
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT_S > 0) ? TIMEOUT_S - 1 : 0);

  state_t        state_q;
  logic          run_en_q, ld_n_q, editing_q, blink_q;
  logic [23:0]   set_time_q;
  logic [BW-1:0] blink_cnt_q;
  logic [TW-1:0] tmo_q;
  logic [2:0]    mode_sync_q, inc_sync_q;
  logic          press_mode, press_inc, press_step, step_up;
  logic [1:0]    fld_sel;
  logic [7:0]    fld_val, fld_max, fld_res, le_mask;

  assign press_mode = mode_sync_q[1] & ~mode_sync_q[2];
  assign press_inc  = inc_sync_q[1] & ~inc_sync_q[2];

`ifdef CLKSET_DEC_EN
  logic [2:0] dec_sync_q;
  logic       press_dec;
  assign press_dec  = dec_sync_q[1] & ~dec_sync_q[2];
  assign press_step = press_inc | press_dec;
  assign step_up    = press_inc;
`else
  assign press_step = press_inc;
  assign step_up    = 1'b1;
`endif

  always_comb begin
    fld_sel = FLD_SEC;
    case (state_q)
      ST_SET_HOUR: fld_sel = FLD_HOUR;
      ST_SET_MIN:  fld_sel = FLD_MIN;
      default:     ;
    endcase
    fld_val = set_time_q[7:0];
    fld_max = MINSEC_MAX;
    case (fld_sel)
      FLD_HOUR: begin fld_val = set_time_q[23:16]; fld_max = HOUR_MAX; end
      FLD_MIN:  fld_val = set_time_q[15:8];
      default:  ;
    endcase
  end

  bcd_field_step u_step (.val_i(fld_val), .max_i(fld_max), .up_i(step_up), .res_o(fld_res));

  always_comb begin
    le_mask = LE_IDLE;
    if (blink_q) begin
      case (state_q)
        ST_SET_HOUR: le_mask = LE_IDLE | LE_HOUR_BITS;
        ST_SET_MIN:  le_mask = LE_IDLE | LE_MIN_BITS;
        ST_SET_SEC:  le_mask = LE_IDLE | LE_SEC_BITS;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_sync_q <= '0;
      inc_sync_q  <= '0;
`ifdef CLKSET_DEC_EN
      dec_sync_q  <= '0;
`endif
      state_q     <= ST_RUN;
      run_en_q    <= 1'b1;
      ld_n_q      <= 1'b1;
      editing_q   <= 1'b0;
      set_time_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      tmo_q       <= '0;
    end else begin
      mode_sync_q <= {mode_sync_q[1:0], bus.btn_mode};
      inc_sync_q  <= {inc_sync_q[1:0], bus.btn_inc};
`ifdef CLKSET_DEC_EN
      dec_sync_q  <= {dec_sync_q[1:0], bus.btn_dec};
`endif
      // Held clear while running, so every edit starts on the visible phase.
      if (!editing_q) begin
        blink_cnt_q <= '0;
        blink_q     <= 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end

      case (state_q)
        ST_RUN: begin
          run_en_q <= 1'b1;
          ld_n_q   <= 1'b1;
          tmo_q    <= '0;
          if (press_mode) begin
            set_time_q <= {bcd_sanitize(bus.cur_time[23:16], 1'b1),
                           bcd_sanitize(bus.cur_time[15:8], 1'b0),
                           bcd_sanitize(bus.cur_time[7:0], 1'b0)};
            run_en_q  <= 1'b0;
            editing_q <= 1'b1;
            state_q   <= ST_SET_HOUR;
          end
        end
        ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
          if (press_mode) begin
            tmo_q <= '0;
            if (state_q == ST_SET_HOUR)
              state_q <= ST_SET_MIN;
            else if (state_q == ST_SET_MIN)
              state_q <= ST_SET_SEC;
            else begin
              state_q <= ST_COMMIT;
              ld_n_q  <= 1'b0;
            end
          end else if (press_step) begin
            tmo_q <= '0;
            case (fld_sel)
              FLD_HOUR: set_time_q[23:16] <= fld_res;
              FLD_MIN:  set_time_q[15:8]  <= fld_res;
              default:  set_time_q[7:0]   <= fld_res;
            endcase
          end else if (bus.tick_1s && TIMEOUT_S != 0) begin
            if (tmo_q == TMO_LAST) begin
              tmo_q     <= '0;
              run_en_q  <= 1'b1;
              editing_q <= 1'b0;
              state_q   <= ST_RUN;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          // The counters load on this tick's edge; release Ld right after it.
          if (bus.tick_1s) begin
            ld_n_q    <= 1'b1;
            run_en_q  <= 1'b1;
            editing_q <= 1'b0;
            state_q   <= ST_RUN;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          run_en_q  <= 1'b1;
          ld_n_q    <= 1'b1;
          editing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.run_en   = run_en_q;
  assign bus.ld_n     = ld_n_q;
  assign bus.set_time = set_time_q;
  assign bus.le_mask  = le_mask;
  assign bus.editing  = editing_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed-vector bench for clock_set_ctrl with BLINK_DIV=4, TIMEOUT_S=3.
module tb_clock_set_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic mon_en = 1'b0;
  logic ld_low_seen = 1'b0;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(.BLINK_DIV(4), .TIMEOUT_S(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mon_en && !bus.ld_n) ld_low_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 0 = mode, 1 = inc, 2 = dec, 3 = mode+inc together
  task automatic press(input int which);
    if (which == 0 || which == 3) bus.btn_mode = 1'b1;
    if (which == 1 || which == 3) bus.btn_inc = 1'b1;
`ifdef CLKSET_DEC_EN
    if (which == 2) bus.btn_dec = 1'b1;
`endif
    step(4);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
`ifdef CLKSET_DEC_EN
    bus.btn_dec  = 1'b0;
`endif
    step(3);
  endtask

  task automatic tick();
    bus.tick_1s = 1'b1;
    step(1);
    bus.tick_1s = 1'b0;
    step(1);
  endtask

  initial begin
    logic [7:0] v, other;
    int waitc;
    logic found;

    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
`ifdef CLKSET_DEC_EN
    bus.btn_dec  = 1'b0;
`endif
    bus.tick_1s  = 1'b0;
    bus.cur_time = 24'h125959;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_run_en",   bus.run_en,   1);
    chk("rst_ld_n",     bus.ld_n,     1);
    chk("rst_set_time", bus.set_time, 0);
    chk("rst_le_mask",  bus.le_mask,  8'hC0);
    chk("rst_editing",  bus.editing,  0);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("run_run_en",  bus.run_en,  1);
    chk("run_ld_n",    bus.ld_n,    1);
    chk("run_le_mask", bus.le_mask, 8'hC0);
    chk("run_editing", bus.editing, 0);

    // Capture: run_en should drop at the third edge after the press.
    bus.cur_time = 24'h235958;
    bus.btn_mode = 1'b1;
    found = 1'b0;
    for (int i = 1; i <= 4 && !found; i++) begin
      @(negedge clk);
      if (!bus.run_en) found = 1'b1;
    end
    chk("capture_latency", found, 1);
    chk("capture_time",    bus.set_time, 24'h235958);
    chk("capture_editing", bus.editing, 1);
    chk("capture_phase0",  bus.le_mask, 8'hC0);
    @(posedge clk); #1;
    bus.btn_mode = 1'b0;
    step(3);

    press(1);
    chk("hour_wrap", bus.set_time, 24'h005958);

    press(0);
    press(1);
    press(1);
    chk("min_wrap", bus.set_time, 24'h000158);

    // Blink in SET_MIN: four cycles per phase, alternating C0/CC.
    @(negedge clk);
    v = bus.le_mask;
    waitc = 0;
    while (bus.le_mask == v && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    chk("blink_toggle_seen", waitc < 10, 1);
    v = bus.le_mask;
    other = (v == 8'hC0) ? 8'hCC : 8'hC0;
    chk("blink_value", (v == 8'hC0 || v == 8'hCC), 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("blink_%0d", i), bus.le_mask, (i < 4) ? v : other);
    end
    @(posedge clk); #1;

    press(0);
    press(1);
    press(1);
    chk("sec_wrap", bus.set_time, 24'h000100);

    press(0);
    chk("commit_ld_n",   bus.ld_n,   0);
    chk("commit_run_en", bus.run_en, 0);
    step(5);
    chk("commit_hold_ld_n", bus.ld_n, 0);
    press(1);
    chk("commit_frozen", bus.set_time, 24'h000100);
    bus.tick_1s = 1'b1;
    @(negedge clk);
    chk("commit_ld_n_on_tick", bus.ld_n, 0);
    @(posedge clk); #1;
    bus.tick_1s = 1'b0;
    @(negedge clk);
    chk("commit_done_ld_n",    bus.ld_n,    1);
    chk("commit_done_run_en",  bus.run_en,  1);
    chk("commit_done_editing", bus.editing, 0);
    chk("commit_done_le_mask", bus.le_mask, 8'hC0);
    @(posedge clk); #1;

    // Timeout: a press restarts the count, three quiet ticks abort.
    bus.cur_time = 24'h101010;
    ld_low_seen = 1'b0;
    mon_en = 1'b1;
    press(0);
    tick();
    tick();
    chk("tmo_still_edit_2", bus.editing, 1);
    press(1);
    tick();
    tick();
    chk("tmo_cleared_by_press", bus.editing, 1);
    tick();
    chk("tmo_exit_editing", bus.editing, 0);
    chk("tmo_exit_run_en",  bus.run_en,  1);
    chk("tmo_set_time",     bus.set_time, 24'h111010);
    chk("tmo_no_load",      ld_low_seen, 0);
    mon_en = 1'b0;

    // Invalid capture and simultaneous mode+inc.
    bus.cur_time = 24'h3A5F09;
    press(0);
    chk("invalid_capture", bus.set_time, 24'h000009);
    press(3);
    chk("mode_wins_time", bus.set_time, 24'h000009);
    press(1);
    chk("mode_wins_in_min", bus.set_time, 24'h000109);
`ifdef CLKSET_DEC_EN
    press(2);
    chk("dec_min", bus.set_time, 24'h000009);
    press(2);
    chk("dec_min_wrap", bus.set_time, 24'h005909);
`endif
    press(0);
    press(0);
    chk("commit2_ld_n", bus.ld_n, 0);

    #2 rst_n = 1'b0;
    #1;
    chk("arst_ld_n",     bus.ld_n,     1);
    chk("arst_run_en",   bus.run_en,   1);
    chk("arst_set_time", bus.set_time, 0);
    chk("arst_le_mask",  bus.le_mask,  8'hC0);
    chk("arst_editing",  bus.editing,  0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
